writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter: NUM_SRC, 3, number of result sources; index 0 is highest base priority.
REQ-002 Parameter: XLEN, 32, result data width.
REQ-003 Parameter: DEPTH, 2, entries per source FIFO; power of two, >=2.
REQ-004 Parameter: STARVE_LIMIT, 4, consecutive lost arbitrations before promotion; >=1.
REQ-005 Port: clk  in  1  single clock; all state on rising edge.
REQ-006 Port: rst  in  1  reset, synchronous, active-high.
REQ-007 Port: src_valid  in  NUM_SRC  per-source result valid.
REQ-008 Port: src_ready  out  NUM_SRC  per-source accept.
REQ-009 Port: src_data  in  NUM_SRC*XLEN  per-source result value.
REQ-010 Port: src_rd  in  NUM_SRC*5  per-source destination register.
REQ-011 Port: src_is_fp  in  NUM_SRC  1 = FP register file target, 0 = integer.
REQ-012 Port: int_we / int_waddr / int_wdata  out  1/5/XLEN  integer register-file write port.
REQ-013 Port: fp_we / fp_waddr / fp_wdata  out  1/5/XLEN  FP register-file write port.
REQ-014 Port: busy  out  1  any FIFO non-empty or any we asserted.

Function
REQ-015 Transfer occurs on an edge where src_valid[i] and src_ready[i] are both 1; entry {data, rd, is_fp} is pushed into FIFO i.
REQ-016 src_ready[i] = FIFO i not full; no combinational dependency on src_valid or grants.
REQ-017 A full FIFO is not pushed; a popped-full FIFO raises ready only on the following cycle.
REQ-018 Each cycle, two independent arbitrations run: one among non-empty FIFOs whose head has is_fp=0, one among those with is_fp=1.
REQ-019 Arbitration order within a file: promoted sources first, lowest index wins; otherwise lowest index wins.
REQ-020 Winner's head is popped at the edge; int_*/fp_* outputs are registered and present the popped entry for exactly one cycle after that edge.
REQ-021 Latency: entry accepted at edge k, uncontended, gives we=1 in the cycle after edge k+1; there is no bypass of an empty FIFO.
REQ-022 Same-edge push and pop of one FIFO is legal; occupancy is unchanged; FIFO order is strictly preserved.
REQ-023 Integer head with rd=0 is arbitrated and popped normally, but int_we stays 0 for that cycle; FP rd=0 is written.
REQ-024 Per-source starve counter: increments, saturating at STARVE_LIMIT, when the head is valid and loses; clears on grant or when the FIFO is empty.
REQ-025 Source is promoted while its counter equals STARVE_LIMIT.
REQ-026 When we=0, waddr and wdata hold their previous values.
REQ-027 The integer and FP ports may both assert in the same cycle, from different sources or from two FIFOs.

Reset
REQ-028 With rst=1 at an edge, all FIFOs empty, pointers and starve counters zero, int_we=fp_we=0, waddr=0, wdata=0.
REQ-029 During reset and the first cycle after, src_ready=0; pending entries are discarded, not written.
REQ-030 Reset mid-operation is legal; a transfer coinciding with a reset edge is dropped.

Structure
REQ-031 Package wb_pkg holds wb_entry_t {data, rd, is_fp}, the REG_ADDR_W=5 constant and defaults for XLEN and DEPTH.
REQ-032 One sub-module, wb_src_fifo (parametrised by DEPTH, payload wb_entry_t), instantiated NUM_SRC times; arbitration and starve logic stay in the top.

Verification
REQ-033 Single source: src0 sends data=0x0000_00AA, rd=5, is_fp=0 at edge k -> int_we=1, int_waddr=5, int_wdata=0xAA in the cycle after edge k+1; fp_we stays 0.
REQ-034 Dual port: src0 int rd=3 data=0x11 and src2 FP rd=7 data=0x3F80_0000 on the same edge -> int_we and fp_we both 1 in the same cycle with those values.
REQ-035 Starvation: src0 and src1 both stream int results every cycle with STARVE_LIMIT=4 -> src1 wins after 4 consecutive losses, and its counter clears.
REQ-036 Back-pressure: src2 pushes 3 int entries while src0 monopolises the integer port with DEPTH=2 -> src_ready[2]=0 after 2 pushes; third entry is held, then written in order.
REQ-037 x0: int rd=0 data=0xDEAD -> FIFO pops, int_we stays 0; next entry rd=1 is written on the following cycle.
REQ-038 Reset with 2 entries pending -> no writes afterwards, busy=0, and src_ready=1 two cycles after rst falls.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter slice.
package wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WB_XLEN    = 32;
    localparam int unsigned WB_DEPTH   = 2;

    typedef struct packed {
        logic [WB_XLEN-1:0]    data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_fp;
    } wb_entry_t;

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO; power-of-two depth, pointer wrap by natural overflow.
module wb_src_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH   = WB_DEPTH,
    parameter type         entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates buffered result sources onto the integer and FP register-file write ports,
// with fixed priority plus starvation promotion per file.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 3,
    parameter int unsigned XLEN         = WB_XLEN,
    parameter int unsigned DEPTH        = WB_DEPTH,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC-1:0]               src_valid,
    output logic [NUM_SRC-1:0]               src_ready,
    input  logic [NUM_SRC*XLEN-1:0]          src_data,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]    src_rd,
    input  logic [NUM_SRC-1:0]               src_is_fp,
    output logic                             int_we,
    output logic [REG_ADDR_W-1:0]            int_waddr,
    output logic [XLEN-1:0]                  int_wdata,
    output logic                             fp_we,
    output logic [REG_ADDR_W-1:0]            fp_waddr,
    output logic [XLEN-1:0]                  fp_wdata,
    output logic                             busy
);

    // Same layout as wb_entry_t, resized to this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0]       data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_fp;
    } entry_t;

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    entry_t             push_ent [NUM_SRC];
    entry_t             head     [NUM_SRC];
    logic [CW-1:0]      starve   [NUM_SRC];
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] int_req;
    logic [NUM_SRC-1:0] fp_req;
    logic [NUM_SRC-1:0] promoted;
    logic [NUM_SRC-1:0] int_gnt;
    logic [NUM_SRC-1:0] fp_gnt;
    entry_t             int_sel;
    entry_t             fp_sel;
    logic               ready_en;

    // Promoted requesters form the pool if any exist; lowest set bit wins.
    function automatic logic [NUM_SRC-1:0] pick(input logic [NUM_SRC-1:0] req,
                                                input logic [NUM_SRC-1:0] prom);
        logic [NUM_SRC-1:0] pool;
        pool = (|(req & prom)) ? (req & prom) : req;
        return pool & (~pool + NUM_SRC'(1));
    endfunction

    assign src_ready = ~full & {NUM_SRC{ready_en & ~rst}};
    assign push      = src_valid & src_ready;
    assign pop       = int_gnt | fp_gnt;
    assign busy      = ~(&empty) | int_we | fp_we;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign push_ent[g] = '{data:  src_data[g*XLEN +: XLEN],
                               rd:    src_rd[g*REG_ADDR_W +: REG_ADDR_W],
                               is_fp: src_is_fp[g]};

        wb_src_fifo #(
            .DEPTH   (DEPTH),
            .entry_t (entry_t)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[g]),
            .push_data (push_ent[g]),
            .pop       (pop[g]),
            .head      (head[g]),
            .full      (full[g]),
            .empty     (empty[g])
        );
    end

    always_comb begin
        int_req  = '0;
        fp_req   = '0;
        promoted = '0;
        int_sel  = '0;
        fp_sel   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            int_req[i]  = ~empty[i] & ~head[i].is_fp;
            fp_req[i]   = ~empty[i] &  head[i].is_fp;
            promoted[i] = (starve[i] == CW'(STARVE_LIMIT));
        end
        int_gnt = pick(int_req, promoted);
        fp_gnt  = pick(fp_req, promoted);
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (int_gnt[i]) int_sel = head[i];
            if (fp_gnt[i])  fp_sel  = head[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (rst || empty[i] || pop[i]) begin
                starve[i] <= '0;
            end else if (starve[i] != CW'(STARVE_LIMIT)) begin
                starve[i] <= starve[i] + 1'b1;
            end
        end
    end

    // x0 entries are consumed without a write, so the address/data keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en  <= 1'b0;
            int_we    <= 1'b0;
            int_waddr <= '0;
            int_wdata <= '0;
            fp_we     <= 1'b0;
            fp_waddr  <= '0;
            fp_wdata  <= '0;
        end else begin
            ready_en <= 1'b1;
            int_we   <= (|int_gnt) && (int_sel.rd != '0);
            if ((|int_gnt) && (int_sel.rd != '0)) begin
                int_waddr <= int_sel.rd;
                int_wdata <= int_sel.data;
            end
            fp_we <= |fp_gnt;
            if (|fp_gnt) begin
                fp_waddr <= fp_sel.rd;
                fp_wdata <= fp_sel.data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int NS = 3;
    localparam int XL = 32;
    localparam int DP = 2;
    localparam int SL = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*XL-1:0]  src_data;
    logic [NS*5-1:0]   src_rd;
    logic [NS-1:0]     src_is_fp;
    logic              int_we;
    logic [4:0]        int_waddr;
    logic [XL-1:0]     int_wdata;
    logic              fp_we;
    logic [4:0]        fp_waddr;
    logic [XL-1:0]     fp_wdata;
    logic              busy;

    always #5 clk = ~clk;

    writeback_arbiter #(
        .NUM_SRC      (NS),
        .XLEN         (XL),
        .DEPTH        (DP),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_data  (src_data),
        .src_rd    (src_rd),
        .src_is_fp (src_is_fp),
        .int_we    (int_we),
        .int_waddr (int_waddr),
        .int_wdata (int_wdata),
        .fp_we     (fp_we),
        .fp_waddr  (fp_waddr),
        .fp_wdata  (fp_wdata),
        .busy      (busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        fp;
    } ent_t;

    ent_t        mq [NS][$];
    int          starve [NS];
    bit          m_rdy_en = 1'b0;
    logic [NS-1:0] m_acc;
    logic        m_int_we = 1'b0;
    logic        m_fp_we = 1'b0;
    logic [4:0]  m_int_waddr = '0;
    logic [4:0]  m_fp_waddr = '0;
    logic [31:0] m_int_wdata = '0;
    logic [31:0] m_fp_wdata = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_src(input int i, input bit v, input logic [31:0] d,
                           input logic [4:0] rd, input bit fp);
        src_valid[i]        = v;
        src_data[i*XL +: XL] = d;
        src_rd[i*5 +: 5]     = rd;
        src_is_fp[i]         = fp;
    endtask

    task automatic idle();
        src_valid = '0;
    endtask

    // Winner for one file: first promoted head of that file, else first head of that file.
    function automatic int winner(input bit fp);
        for (int i = 0; i < NS; i++)
            if (mq[i].size() > 0 && mq[i][0].fp == fp && starve[i] >= SL) return i;
        for (int i = 0; i < NS; i++)
            if (mq[i].size() > 0 && mq[i][0].fp == fp) return i;
        return -1;
    endfunction

    task automatic model_edge(input logic [NS-1:0] acc);
        int wi;
        int wf;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                mq[i].delete();
                starve[i] = 0;
            end
            m_rdy_en = 1'b0;
            m_int_we = 1'b0; m_int_waddr = '0; m_int_wdata = '0;
            m_fp_we  = 1'b0; m_fp_waddr  = '0; m_fp_wdata  = '0;
            return;
        end
        wi = winner(1'b0);
        wf = winner(1'b1);
        m_int_we = 1'b0;
        if (wi >= 0 && mq[wi][0].rd != 5'd0) begin
            m_int_we    = 1'b1;
            m_int_waddr = mq[wi][0].rd;
            m_int_wdata = mq[wi][0].data;
        end
        m_fp_we = (wf >= 0);
        if (wf >= 0) begin
            m_fp_waddr = mq[wf][0].rd;
            m_fp_wdata = mq[wf][0].data;
        end
        for (int i = 0; i < NS; i++) begin
            if (mq[i].size() == 0 || i == wi || i == wf) starve[i] = 0;
            else if (starve[i] < SL) starve[i] = starve[i] + 1;
        end
        if (wi >= 0) void'(mq[wi].pop_front());
        if (wf >= 0) void'(mq[wf].pop_front());
        for (int i = 0; i < NS; i++)
            if (acc[i]) mq[i].push_back(ent_t'{data: src_data[i*XL +: XL],
                                               rd:   src_rd[i*5 +: 5],
                                               fp:   src_is_fp[i]});
        m_rdy_en = 1'b1;
    endtask

    task automatic tick();
        logic [NS-1:0] exp_rdy;
        bit any;
        @(negedge clk);
        for (int i = 0; i < NS; i++)
            exp_rdy[i] = m_rdy_en && !rst && (mq[i].size() < DP);
        chk("src_ready", src_ready, exp_rdy);
        m_acc = src_valid & exp_rdy;
        @(posedge clk);
        model_edge(m_acc);
        #1;
        any = 1'b0;
        for (int i = 0; i < NS; i++) if (mq[i].size() > 0) any = 1'b1;
        chk("int_we", int_we, m_int_we);
        chk("int_waddr", int_waddr, m_int_waddr);
        chk("int_wdata", int_wdata, m_int_wdata);
        chk("fp_we", fp_we, m_fp_we);
        chk("fp_waddr", fp_waddr, m_fp_waddr);
        chk("fp_wdata", fp_wdata, m_fp_wdata);
        chk("busy", busy, any | m_int_we | m_fp_we);
    endtask

    initial begin
        int  n0;
        bit  seen1;
        int  sent;
        int  got;

        rst = 1'b1;
        src_valid = '0; src_data = '0; src_rd = '0; src_is_fp = '0;
        for (int i = 0; i < NS; i++) starve[i] = 0;
        tick(); tick();
        chk("reset_int_we", int_we, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;
        tick(); tick();

        // single source, uncontended latency
        set_src(0, 1'b1, 32'h0000_00AA, 5'd5, 1'b0);
        tick();
        idle();
        tick();
        chk("single_we", int_we, 1'b1);
        chk("single_waddr", int_waddr, 5'd5);
        chk("single_wdata", int_wdata, 32'hAA);
        chk("single_fp_we", fp_we, 1'b0);
        tick();

        // both ports in the same cycle
        set_src(0, 1'b1, 32'h11, 5'd3, 1'b0);
        set_src(2, 1'b1, 32'h3F80_0000, 5'd7, 1'b1);
        tick();
        idle();
        tick();
        chk("dual_int_we", int_we, 1'b1);
        chk("dual_int_waddr", int_waddr, 5'd3);
        chk("dual_int_wdata", int_wdata, 32'h11);
        chk("dual_fp_we", fp_we, 1'b1);
        chk("dual_fp_waddr", fp_waddr, 5'd7);
        chk("dual_fp_wdata", fp_wdata, 32'h3F80_0000);
        tick();

        // starvation: src1 must win after exactly SL losses to src0
        n0 = 0; seen1 = 1'b0;
        for (int c = 0; c < 14; c++) begin
            set_src(0, 1'b1, 32'h100 + c, 5'd1, 1'b0);
            set_src(1, 1'b1, 32'h200 + c, 5'd2, 1'b0);
            tick();
            if (int_we && !seen1) begin
                if (int_waddr == 5'd2) begin
                    seen1 = 1'b1;
                    chk("starve_losses", n0, SL);
                end else begin
                    n0++;
                end
            end
        end
        chk("starve_promoted", seen1, 1'b1);
        idle();
        repeat (6) tick();

        // back-pressure: src2 queues 3 int entries behind a busy src0
        sent = 0; got = 0;
        for (int c = 0; c < 24; c++) begin
            set_src(0, c < 12, 32'h300 + c, 5'd1, 1'b0);
            set_src(2, sent < 3, 32'h400 + sent, 5'(10 + sent), 1'b0);
            tick();
            if (m_acc[2]) sent++;
            if (int_we && int_waddr >= 5'd10 && int_waddr <= 5'd12) begin
                chk("bp_order", int_waddr, 5'(10 + got));
                got++;
            end
        end
        chk("bp_count", got, 3);
        idle();
        tick();

        // x0 destination: consumed without a write, next entry written one cycle later
        set_src(0, 1'b1, 32'hDEAD, 5'd0, 1'b0);
        tick();
        set_src(0, 1'b1, 32'h1234, 5'd1, 1'b0);
        tick();
        chk("x0_we", int_we, 1'b0);
        idle();
        tick();
        chk("x0_next_we", int_we, 1'b1);
        chk("x0_next_waddr", int_waddr, 5'd1);
        chk("x0_next_wdata", int_wdata, 32'h1234);
        tick();

        // reset with pending entries
        set_src(0, 1'b1, 32'h55, 5'd4, 1'b0);
        set_src(1, 1'b1, 32'h66, 5'd6, 1'b1);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_pend_int_we", int_we, 1'b0);
        chk("rst_pend_fp_we", fp_we, 1'b0);
        chk("rst_pend_busy", busy, 1'b0);
        tick();
        tick();

        // random traffic with occasional reset
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NS; i++)
                set_src(i, $urandom_range(0, 99) < 65, $urandom,
                        5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            rst = ($urandom_range(0, 79) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
